// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants: FSM state encoding, reset PC, increment and NOP.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_HOLD  = ST_HOLD,
    S_FLUSH = ST_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/pc_adder.sv
// Sequential PC increment; wraps modulo 2^32 with no carry out.
module pc_adder (
  input  logic [31:0] a,
  input  logic [31:0] inc,
  output logic [31:0] sum
);

  assign sum = a + inc;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC sequencer: one outstanding imem request, registered IF/ID outputs,
// trap/branch redirects that squash wrong-path fetches.
//
// state   | meaning
// IDLE    | first cycle after reset, nothing issued
// REQ     | request pending on imem at pc
// WAIT    | request accepted, waiting for its response
// HOLD    | instruction presented to IF/ID until if_ready
// FLUSH   | wrong-path response still outstanding, drop it when it arrives
module fetch_pc_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus, req_pc;
  logic [31:0]  target;
  logic         redir_req, target_bad, redir;
  logic         issue, capture;

  assign target     = trap_valid ? trap_pc : redirect_pc;
  assign redir_req  = trap_valid | redirect_valid;
  assign target_bad = |target[1:0];
  // A misaligned target cancels the whole redirect, trap included.
  assign redir      = redir_req & ~target_bad;

  pc_adder u_pc_adder (
    .a   (pc),
    .inc (PC_INC),
    .sum (pc_plus)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    issue     = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          issue     = 1'b1;
          pc_nxt    = pc_plus;
          state_nxt = redir ? S_FLUSH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          capture   = ~redir;
          state_nxt = redir ? S_REQ : S_HOLD;
        end else if (redir) begin
          state_nxt = S_FLUSH;
        end
      end
      S_HOLD: begin
        if (redir || if_ready) state_nxt = S_REQ;
      end
      S_FLUSH: begin
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Every state takes the redirect target on the same edge.
    if (redir) pc_nxt = target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= NOP_INSTR;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      if (issue) req_pc <= pc;
      if (capture) begin
        if_pc    <= req_pc;
        if_instr <= imem_rsp_data;
      end
      if_valid <= (state_nxt == S_HOLD);
      misalign <= redir_req & target_bad;
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed redirect/trap/stall/wrap/reset
// scenarios against a latency-programmable imem responder.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        misalign;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int rsp_lat = 1;

  logic [31:0] exp_req[$];
  logic [31:0] exp_if[$];
  int          exp_mis[$];

  fetch_pc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    cmp_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return imem_req_valid && imem_req_ready;
      1:       return if_valid;
      default: return imem_req_valid;
    endcase
  endfunction

  // Stops on the first negedge where the selected event is visible.
  task automatic wait_for(input string name, input int sel, output int t);
    int n;
    n = 0;
    t = -1;
    @(negedge clk);
    while (!probe(sel) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (probe(sel)) t = cyc;
    else begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: event not seen after %0d cycles, expected it", name, n);
    end
  endtask

  // imem model: response rsp_lat cycles after acceptance, data derived from address.
  initial begin : responder
    logic        acc;
    logic [31:0] acc_addr;
    int          acc_lat;
    logic [31:0] pend;
    int          cnt;
    cnt  = 0;
    pend = '0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      acc_lat  = rsp_lat;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (acc) begin
        pend = acc_addr;
        cnt  = acc_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(pend);
        end
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    int          m;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
        end else check32("req_addr", imem_req_addr, exp_req.pop_front());
      end
      if (if_valid && if_ready) begin
        if (exp_if.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL if_unexpected: got pc %h expected no instruction", if_pc);
        end else begin
          e = exp_if.pop_front();
          check32("if_pc", if_pc, e);
          check32("if_instr", if_instr, instr_of(e));
        end
      end
      if (misalign) begin
        if (exp_mis.size() == 0) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL misalign_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          m = exp_mis.pop_front();
          check32("misalign_cycle", cyc, m);
        end
      end
    end
  end

  initial begin : stimulus
    int t0, t1, td;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_valid     = 1'b0;
    trap_pc        = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check32("rst_req_addr", imem_req_addr, 32'h0);
    check32("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_instr", if_instr, 32'h0000_0013);
    check32("rst_misalign", {31'b0, misalign}, 32'd0);

    // Sequential fetch, then a 5-cycle IF/ID stall on the second instruction.
    tick();
    rst_n = 1'b1;
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_if.push_back(32'h0);  exp_if.push_back(32'h4);
    @(negedge clk);
    check32("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
    wait_for("accept_0", 0, t0);
    tick();
    wait_for("accept_4", 0, t1);
    check32("cadence_0_4", t1 - t0, 32'd3);
    tick();
    if_ready = 1'b0;
    wait_for("hold_4", 1, td);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check32("hold_if_valid", {31'b0, if_valid}, 32'd1);
      check32("hold_if_pc", if_pc, 32'h4);
      check32("hold_if_instr", if_instr, instr_of(32'h4));
      check32("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    tick();
    if_ready = 1'b1;
    rsp_lat  = 3;

    // Branch in WAIT; the late response for 0x8 must be dropped.
    wait_for("accept_8", 0, td);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    rsp_lat        = 1;
    exp_req.push_back(32'h100);
    tick();
    redirect_valid = 1'b0;

    // Trap and branch together in HOLD: trap wins, held instruction killed.
    wait_for("accept_100", 0, td);
    tick();
    if_ready = 1'b0;
    wait_for("hold_100", 1, td);
    check32("hold100_if_pc", if_pc, 32'h100);
    tick();
    trap_valid     = 1'b1;
    trap_pc        = 32'h80;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_req.push_back(32'h80);
    exp_if.push_back(32'h80);
    tick();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    wait_for("accept_80", 0, td);
    check32("kill_if_valid", {31'b0, if_valid}, 32'd0);

    // Misaligned branch target ignored, fetch continues sequentially.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    exp_mis.push_back(cyc + 1);
    exp_req.push_back(32'h84);
    exp_if.push_back(32'h84);
    tick();
    redirect_valid = 1'b0;

    // Misaligned trap target ignored while HOLD stalls.
    wait_for("accept_84", 0, td);
    tick();
    if_ready = 1'b0;
    wait_for("hold_84", 1, td);
    tick();
    trap_valid     = 1'b1;
    trap_pc        = 32'h81;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    exp_mis.push_back(cyc + 1);
    exp_req.push_back(32'h88);
    exp_if.push_back(32'h88);
    tick();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("mistrap_if_valid", {31'b0, if_valid}, 32'd1);
    check32("mistrap_if_pc", if_pc, 32'h84);
    tick();
    if_ready = 1'b1;

    // Redirect a pending (not yet accepted) request to the top of memory.
    wait_for("accept_88", 0, td);
    tick();
    imem_req_ready = 1'b0;
    wait_for("pending_8c", 2, td);
    check32("pending_addr", imem_req_addr, 32'h8C);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_if.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_for("accept_fffffffc", 0, t0);
    tick();
    rsp_lat = 3;
    wait_for("accept_wrap_0", 0, t1);
    check32("cadence_wrap", t1 - t0, 32'd3);

    // Reset while WAITing; the stale response lands in REQ and is ignored.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    check32("rst2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check32("rst2_if_valid", {31'b0, if_valid}, 32'd0);
    check32("rst2_if_instr", if_instr, 32'h0000_0013);
    check32("rst2_req_addr", imem_req_addr, 32'h0);
    tick();
    @(negedge clk);
    check32("rst2_req_pending", {31'b0, imem_req_valid}, 32'd1);
    check32("rst2_stale_addr", imem_req_addr, 32'h0);
    check32("rst2_stale_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    imem_req_ready = 1'b1;
    rsp_lat        = 1;
    exp_req.push_back(32'h0);
    exp_if.push_back(32'h0);
    wait_for("accept_rst_0", 0, td);
    tick();
    imem_req_ready = 1'b0;

    for (int i = 0; i < 20 && exp_if.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check32("left_req", exp_req.size(), 32'd0);
    check32("left_if", exp_if.size(), 32'd0);
    check32("left_mis", exp_mis.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Program-counter sequencer for the IF stage of the five-stage pipeline. Owns the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and presents each fetched instruction to IF/ID with its PC. Applies trap and branch/jump redirects from later stages, discarding any in-flight or held wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- PC_INC, 32'd4, sequential increment
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- redirect_valid  in  1  branch/jump taken pulse from EX
- redirect_pc  in  32  branch/jump target
- trap_valid  in  1  trap pulse; priority over redirect_valid
- trap_pc  in  32  trap vector
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  32  fetch address
- imem_req_ready  in  1  imem accepts request
- imem_rsp_valid  in  1  instruction returned, one per accepted request
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction valid to IF/ID
- if_pc  out  32  PC of if_instr
- if_instr  out  32  fetched instruction
- if_ready  in  1  IF/ID accepts (low = hazard stall)
- misalign  out  1  one-cycle pulse: rejected target with [1:0] != 2'b00

## Operation
- Registers: pc (next fetch address), req_pc (address in flight), if_pc, if_instr, if_valid, state.
- States: IDLE, REQ, WAIT, HOLD, FLUSH. Encoding 3 bits.
- IDLE: one cycle after reset, all outputs low -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready: req_pc<=pc, pc<=pc+PC_INC, -> WAIT. imem_rsp_valid ignored in REQ.
- WAIT: on imem_rsp_valid: if_instr<=imem_rsp_data, if_pc<=req_pc, if_valid<=1, -> HOLD.
- HOLD: if_valid=1, if_pc/if_instr stable. On if_ready: if_valid<=0, -> REQ.
- FLUSH: wait for the outstanding response; on imem_rsp_valid discard it, -> REQ.
- Redirect target = trap_pc if trap_valid else redirect_pc; pc<=target in the same edge. Per state:
  - REQ, no ready: -> REQ; address changes next cycle (the only permitted change of a pending address).
  - REQ with ready same cycle: request issued, -> FLUSH.
  - WAIT without rsp_valid: -> FLUSH. WAIT with rsp_valid same cycle: response discarded, -> REQ.
  - HOLD (with or without if_ready): if_valid<=0, held instruction killed, -> REQ.
  - FLUSH: stays FLUSH, pc updated; a second redirect overwrites pc.
  - IDLE: pc<=target, -> REQ.
- Misaligned target: redirect ignored, misalign=1 for one cycle, state/pc behave as if no redirect. Trap targets are checked as well.
- Arithmetic: pc+PC_INC modulo 2^32; 32'hFFFF_FFFC -> 32'h0000_0000, no flag.

## Timing
- Reset (rst_n low at edge): pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), misalign=0. Stale responses after reset are dropped.
- Minimum cadence: REQ->WAIT->HOLD->REQ, 1 instruction per 3 cycles with zero-latency imem and if_ready=1.
- Redirect-to-new-request latency: 1 cycle (REQ on next edge), plus response wait if FLUSH.
- imem_req_valid and imem_req_addr are registered-state-derived (no combinational path from if_ready or redirect inputs).
- if_valid, if_pc, if_instr are registered.
- At most one request outstanding at any time.

## Structure
- riscv_pkg: state encoding localparams, NOP constant 32'h0000_0013, default RESET_PC.
- Sub-module: pc_adder instance computes pc+PC_INC (inc tied to PC_INC).
- Single FSM always block plus datapath register block; no other hierarchy.

## Test plan
- Reset, imem ready=1, 1-cycle response, if_ready=1 -> requests at 0x0, 0x4, 0x8, each if_pc matches, 3-cycle spacing.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc=0x4, if_instr held; no new imem_req_valid until accept.
- redirect_valid with redirect_pc=0x100 in WAIT, response 3 cycles later -> response dropped (if_valid stays 0), next request addr 0x100.
- trap_valid (trap_pc=0x80) and redirect_valid (0x200) same cycle in HOLD -> held instr killed, next request addr 0x80.
- redirect_pc=0x102 -> misalign pulse, sequential fetch continues at pc+4.
- pc=0xFFFF_FFFC fetched -> next request 0x0000_0000; rst_n low during WAIT -> IDLE, late response ignored, next request RESET_PC.
